// File: rtl/up_wishbone_burst.sv
`default_nettype none
// ============================================================================
// Module   : up_wishbone_burst
// Purpose  : Wishbone B4 slave to simple uP register request/ack bridge with
//            incrementing/wrapping burst addressing and a request timeout.
// Revision : 1.0 - initial release
// ============================================================================
module up_wishbone_burst #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       s_wb_cyc,
    input  logic                                       s_wb_stb,
    input  logic                                       s_wb_we,
    input  logic [ADDRESS_WIDTH-1:0]                   s_wb_addr,
    input  logic [8*BUS_WIDTH-1:0]                     s_wb_data_i,
    input  logic [BUS_WIDTH-1:0]                       s_wb_sel,
    input  logic [2:0]                                 s_wb_cti,
    input  logic [1:0]                                 s_wb_bte,
    output logic                                       s_wb_ack,
    output logic                                       s_wb_err,
    output logic [8*BUS_WIDTH-1:0]                     s_wb_data_o,
    output logic                                       up_rreq,
    input  logic                                       up_rack,
    output logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0] up_raddr,
    input  logic [8*BUS_WIDTH-1:0]                     up_rdata,
    output logic                                       up_wreq,
    input  logic                                       up_wack,
    output logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0] up_waddr,
    output logic [8*BUS_WIDTH-1:0]                     up_wdata,
    output logic [BUS_WIDTH-1:0]                       up_wstrb
);

    localparam int c_DW     = 8 * BUS_WIDTH;
    localparam int c_WS     = $clog2(BUS_WIDTH);
    localparam int c_WAW    = ADDRESS_WIDTH - c_WS;
    localparam int c_WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(TIMEOUT_CYCLES);
    localparam bit   c_TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]          r_state;
    logic                r_ack;
    logic                r_err;
    logic [c_DW-1:0]     r_rdata;
    logic                r_rreq;
    logic                r_wreq;
    logic [c_WAW-1:0]    r_addr;
    logic [c_DW-1:0]     r_wdata;
    logic [BUS_WIDTH-1:0] r_wstrb;
    logic [2:0]          r_cti;
    logic                r_burst;
    logic                r_abort;
    logic [c_WAIT_W-1:0] r_wait;

    logic [c_WAW-1:0]    w_wrap_mask;
    logic [c_WAW-1:0]    w_addr_inc;
    logic [c_WAW-1:0]    w_burst_addr;
    logic [c_WAW-1:0]    w_beat_addr;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic                w_up_ack;
    logic                w_timeout;
    logic                w_abort;
    logic                w_burst_next;

    // Wrapping bursts only advance the low bits inside the aligned block.
    always_comb begin
        w_wrap_mask = '1;
        case (s_wb_bte)
            2'b01:   w_wrap_mask = c_WAW'(3);
            2'b10:   w_wrap_mask = c_WAW'(7);
            2'b11:   w_wrap_mask = c_WAW'(15);
            default: w_wrap_mask = '1;
        endcase
    end

    assign w_addr_inc   = r_addr + c_WAW'(1);
    assign w_burst_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
    assign w_beat_addr  = r_burst ? w_burst_addr : s_wb_addr[ADDRESS_WIDTH-1:c_WS];

    assign w_wait_inc   = r_wait + c_WAIT_W'(1);
    assign w_up_ack     = (r_rreq & up_rack) | (r_wreq & up_wack);
    assign w_timeout    = c_TO_EN && (w_wait_inc == c_TIMEOUT);
    assign w_abort      = r_abort | ~s_wb_cyc;
    assign w_burst_next = (r_cti == 3'b010) ? 1'b1 :
                          ((r_cti == 3'b111) || (r_cti == 3'b000)) ? 1'b0 : r_burst;

    generate
        if (c_WS > 0) begin : g_addr_lsb
            logic w_unused_addr_lsb;
            assign w_unused_addr_lsb = ^s_wb_addr[c_WS-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_rreq  <= 1'b0;
            r_wreq  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_cti   <= 3'b000;
            r_burst <= 1'b0;
            r_abort <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!s_wb_cyc) begin
                        r_burst <= 1'b0;
                    end else if (s_wb_stb && !r_ack && !r_err) begin
                        r_addr  <= w_beat_addr;
                        r_wdata <= s_wb_data_i;
                        r_wstrb <= s_wb_sel;
                        r_cti   <= s_wb_cti;
                        r_wait  <= '0;
                        r_abort <= 1'b0;
                        if (s_wb_we) begin
                            r_state <= c_WRITE;
                            r_wreq  <= 1'b1;
                        end else begin
                            r_state <= c_READ;
                            r_rreq  <= 1'b1;
                        end
                    end
                end
                c_READ, c_WRITE: begin
                    if (w_up_ack) begin
                        r_rreq <= 1'b0;
                        r_wreq <= 1'b0;
                        if (r_rreq) begin
                            r_rdata <= up_rdata;
                        end
                        if (w_abort) begin
                            r_state <= c_IDLE;
                            r_burst <= 1'b0;
                        end else begin
                            r_ack   <= 1'b1;
                            r_state <= c_RESP;
                            r_burst <= w_burst_next;
                        end
                    end else if (w_timeout) begin
                        r_rreq  <= 1'b0;
                        r_wreq  <= 1'b0;
                        r_rdata <= '0;
                        r_burst <= 1'b0;
                        if (w_abort) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_RESP;
                        end
                    end else begin
                        r_wait <= w_wait_inc;
                        // A master that drops cyc mid-request loses its response.
                        if (!s_wb_cyc) begin
                            r_abort <= 1'b1;
                        end
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign s_wb_ack    = r_ack;
    assign s_wb_err    = r_err;
    assign s_wb_data_o = r_rdata;
    assign up_rreq     = r_rreq;
    assign up_wreq     = r_wreq;
    assign up_raddr    = r_addr;
    assign up_waddr    = r_addr;
    assign up_wdata    = r_wdata;
    assign up_wstrb    = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_up_wishbone_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_wishbone_burst
// Purpose  : Directed vector bench for up_wishbone_burst (TIMEOUT_CYCLES = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_wishbone_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_wb_cyc, s_wb_stb, s_wb_we;
    logic [15:0] s_wb_addr;
    logic [31:0] s_wb_data_i;
    logic [3:0]  s_wb_sel;
    logic [2:0]  s_wb_cti;
    logic [1:0]  s_wb_bte;
    logic        s_wb_ack, s_wb_err;
    logic [31:0] s_wb_data_o;
    logic        up_rreq, up_rack;
    logic [13:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_wreq, up_wack;
    logic [13:0] up_waddr;
    logic [31:0] up_wdata;
    logic [3:0]  up_wstrb;

    always #5 clk = ~clk;

    up_wishbone_burst #(
        .ADDRESS_WIDTH  (16),
        .BUS_WIDTH      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_wb_cyc    (s_wb_cyc),
        .s_wb_stb    (s_wb_stb),
        .s_wb_we     (s_wb_we),
        .s_wb_addr   (s_wb_addr),
        .s_wb_data_i (s_wb_data_i),
        .s_wb_sel    (s_wb_sel),
        .s_wb_cti    (s_wb_cti),
        .s_wb_bte    (s_wb_bte),
        .s_wb_ack    (s_wb_ack),
        .s_wb_err    (s_wb_err),
        .s_wb_data_o (s_wb_data_o),
        .up_rreq     (up_rreq),
        .up_rack     (up_rack),
        .up_raddr    (up_raddr),
        .up_rdata    (up_rdata),
        .up_wreq     (up_wreq),
        .up_wack     (up_wack),
        .up_waddr    (up_waddr),
        .up_wdata    (up_wdata),
        .up_wstrb    (up_wstrb)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        keep_cyc;
        int          ack_delay;
        logic [31:0] rdata;
        logic [13:0] exp_addr;
        logic        exp_ack;
        logic        exp_err;
        int          exp_lat;
        int          exp_req;
        logic [31:0] exp_data_o;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One Wishbone beat against a uP that acks on request cycle ack_delay+1.
    task automatic run_beat(input vec_t v, input string tag);
        int   cyc_n;
        int   req_n;
        logic done;
        s_wb_cyc    = 1'b1;
        s_wb_stb    = 1'b1;
        s_wb_we     = v.we;
        s_wb_addr   = v.addr;
        s_wb_data_i = v.wdata;
        s_wb_sel    = v.sel;
        s_wb_cti    = v.cti;
        s_wb_bte    = v.bte;
        up_rdata    = v.rdata;
        up_rack     = 1'b0;
        up_wack     = 1'b0;
        cyc_n = 0;
        req_n = 0;
        done  = 1'b0;
        while (!done && cyc_n < 40) begin
            @(negedge clk);
            cyc_n++;
            up_rack = 1'b0;
            up_wack = 1'b0;
            check({tag, "_req_excl"}, {31'd0, up_rreq & up_wreq}, 32'd0);
            if (s_wb_ack || s_wb_err) begin
                done = 1'b1;
            end else if (up_rreq || up_wreq) begin
                req_n++;
                check({tag, "_req_dir"}, {31'd0, v.we ? up_wreq : up_rreq}, 32'd1);
                check({tag, "_addr"}, {18'd0, v.we ? up_waddr : up_raddr}, {18'd0, v.exp_addr});
                if (v.we) begin
                    check({tag, "_wdata"}, up_wdata, v.wdata);
                    check({tag, "_wstrb"}, {28'd0, up_wstrb}, {28'd0, v.sel});
                end
                if (req_n == v.ack_delay + 1) begin
                    if (v.we) up_wack = 1'b1;
                    else      up_rack = 1'b1;
                end
            end
        end
        check({tag, "_latency"}, cyc_n, v.exp_lat);
        check({tag, "_req_cycles"}, req_n, v.exp_req);
        check({tag, "_ack"}, {31'd0, s_wb_ack}, {31'd0, v.exp_ack});
        check({tag, "_err"}, {31'd0, s_wb_err}, {31'd0, v.exp_err});
        check({tag, "_data_o"}, s_wb_data_o, v.exp_data_o);
        s_wb_stb = 1'b0;
        if (!v.keep_cyc) s_wb_cyc = 1'b0;
        up_rdata = 32'hDEAD_0000;
        @(negedge clk);
        check({tag, "_resp_one_cycle"}, {30'd0, s_wb_ack, s_wb_err}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {28'd0, s_wb_ack, s_wb_err, up_rreq, up_wreq}, 32'd0);
        check({tag, "_data_o"}, s_wb_data_o, 32'd0);
        check({tag, "_raddr"}, {18'd0, up_raddr}, 32'd0);
        check({tag, "_waddr"}, {18'd0, up_waddr}, 32'd0);
        check({tag, "_wdata"}, up_wdata, 32'd0);
        check({tag, "_wstrb"}, {28'd0, up_wstrb}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[19];
        vec_t v;
        logic seen;

        // we addr wdata sel cti bte keep dly rdata | exp_addr ack err lat req data_o
        vecs[0]  = '{1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, 2'b00, 1'b0, 0, 32'hB0BDBEEF, 14'h0002, 1'b1, 1'b0, 2, 1, 32'hB0BDBEEF};
        vecs[1]  = '{1'b1, 16'h000C, 32'hAAAA0005, 4'b0011, 3'b000, 2'b00, 1'b0, 2, 32'hDEADBEEF, 14'h0003, 1'b1, 1'b0, 4, 3, 32'hB0BDBEEF};
        vecs[2]  = '{1'b0, 16'h0008, 32'h0, 4'hF, 3'b010, 2'b01, 1'b1, 0, 32'h11111111, 14'h0002, 1'b1, 1'b0, 2, 1, 32'h11111111};
        vecs[3]  = '{1'b0, 16'h0100, 32'h0, 4'hF, 3'b010, 2'b01, 1'b1, 1, 32'h22222222, 14'h0003, 1'b1, 1'b0, 3, 2, 32'h22222222};
        vecs[4]  = '{1'b0, 16'h0200, 32'h0, 4'hF, 3'b010, 2'b01, 1'b1, 0, 32'h33333333, 14'h0000, 1'b1, 1'b0, 2, 1, 32'h33333333};
        vecs[5]  = '{1'b0, 16'h0300, 32'h0, 4'hF, 3'b111, 2'b01, 1'b0, 0, 32'h44444444, 14'h0001, 1'b1, 1'b0, 2, 1, 32'h44444444};
        vecs[6]  = '{1'b0, 16'h0040, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 1, 32'h55555555, 14'h0010, 1'b1, 1'b0, 3, 2, 32'h55555555};
        vecs[7]  = '{1'b1, 16'h001C, 32'h01020304, 4'hF, 3'b010, 2'b10, 1'b1, 0, 32'hDEADBEEF, 14'h0007, 1'b1, 1'b0, 2, 1, 32'h55555555};
        vecs[8]  = '{1'b0, 16'h0000, 32'h0, 4'hF, 3'b010, 2'b10, 1'b1, 0, 32'h66666666, 14'h0000, 1'b1, 1'b0, 2, 1, 32'h66666666};
        vecs[9]  = '{1'b0, 16'h0000, 32'h0, 4'hF, 3'b000, 2'b10, 1'b0, 0, 32'h77777777, 14'h0001, 1'b1, 1'b0, 2, 1, 32'h77777777};
        vecs[10] = '{1'b0, 16'hFFFC, 32'h0, 4'hF, 3'b010, 2'b00, 1'b1, 0, 32'h88888888, 14'h3FFF, 1'b1, 1'b0, 2, 1, 32'h88888888};
        vecs[11] = '{1'b1, 16'h1234, 32'hCAFEF00D, 4'b1000, 3'b111, 2'b00, 1'b0, 0, 32'hDEADBEEF, 14'h0000, 1'b1, 1'b0, 2, 1, 32'h88888888};
        vecs[12] = '{1'b0, 16'h0078, 32'h0, 4'hF, 3'b010, 2'b11, 1'b1, 0, 32'h99999999, 14'h001E, 1'b1, 1'b0, 2, 1, 32'h99999999};
        vecs[13] = '{1'b0, 16'h0000, 32'h0, 4'hF, 3'b010, 2'b11, 1'b1, 0, 32'hAAAAAAAA, 14'h001F, 1'b1, 1'b0, 2, 1, 32'hAAAAAAAA};
        vecs[14] = '{1'b0, 16'h0000, 32'h0, 4'hF, 3'b111, 2'b11, 1'b0, 0, 32'hBBBBBBBB, 14'h0010, 1'b1, 1'b0, 2, 1, 32'hBBBBBBBB};
        vecs[15] = '{1'b0, 16'h0010, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 7, 32'h5A5A1234, 14'h0004, 1'b1, 1'b0, 9, 8, 32'h5A5A1234};
        vecs[16] = '{1'b0, 16'h0020, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 1000, 32'hCCCCCCCC, 14'h0008, 1'b0, 1'b1, 9, 8, 32'h00000000};
        vecs[17] = '{1'b0, 16'h0050, 32'h0, 4'hF, 3'b010, 2'b00, 1'b1, 1000, 32'hDDDDDDDD, 14'h0014, 1'b0, 1'b1, 9, 8, 32'h00000000};
        vecs[18] = '{1'b0, 16'h0060, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 0, 32'hABCD0001, 14'h0018, 1'b1, 1'b0, 2, 1, 32'hABCD0001};

        rst = 1'b1;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        s_wb_addr = '0; s_wb_data_i = '0; s_wb_sel = '0; s_wb_cti = '0; s_wb_bte = '0;
        up_rack = 1'b0; up_wack = 1'b0; up_rdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            run_beat(vecs[i], $sformatf("v%0d", i));
        end

        // cyc drops during a pending write; uP acks two cycles later.
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
        s_wb_addr = 16'h0030; s_wb_data_i = 32'h12345678; s_wb_sel = 4'hF;
        s_wb_cti = 3'b000; s_wb_bte = 2'b00;
        @(negedge clk);
        check("abort_wreq_n1", {31'd0, up_wreq}, 32'd1);
        check("abort_waddr", {18'd0, up_waddr}, 32'h0C);
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
        @(negedge clk);
        check("abort_wreq_held", {31'd0, up_wreq}, 32'd1);
        up_wack = 1'b1;
        @(negedge clk);
        up_wack = 1'b0;
        check("abort_wreq_drop", {31'd0, up_wreq}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = seen | s_wb_ack | s_wb_err;
            if (k < 3) @(negedge clk);
        end
        check("abort_no_resp", {31'd0, seen}, 32'd0);
        v = '{1'b0, 16'h0034, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 0, 32'h600DF00D, 14'h000D, 1'b1, 1'b0, 2, 1, 32'h600DF00D};
        run_beat(v, "post_abort");

        // Reset while a burst beat is pending; burst state must not survive it.
        v = '{1'b0, 16'h0044, 32'h0, 4'hF, 3'b010, 2'b00, 1'b1, 0, 32'h0F0F0F0F, 14'h0011, 1'b1, 1'b0, 2, 1, 32'h0F0F0F0F};
        run_beat(v, "pre_rst");
        s_wb_stb = 1'b1; s_wb_we = 1'b0; s_wb_addr = 16'h0048;
        s_wb_cti = 3'b010; s_wb_bte = 2'b00;
        @(negedge clk);
        check("rst_pending_rreq", {31'd0, up_rreq}, 32'd1);
        check("rst_pending_raddr", {18'd0, up_raddr}, 32'h12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst_async");
        @(negedge clk);
        check_all_zero("mid_rst");
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_quiet", {30'd0, s_wb_ack, s_wb_err}, 32'd0);
        v = '{1'b0, 16'h0080, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 0, 32'h13579BDF, 14'h0020, 1'b1, 1'b0, 2, 1, 32'h13579BDF};
        run_beat(v, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/up_wishbone_burst.md
UP_WISHBONE_BURST -- requirements
Module: up_wishbone_burst

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16: Wishbone byte-address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 4: data bus width in bytes (power of 2, 1..16). Data width is DW = 8*BUS_WIDTH and the word-address shift is WS = log2(BUS_WIDTH).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum request wait in cycles; 0 disables the timeout.
REQ-004 SHALL have a single clock `clk`; reset `rst` is asynchronous and active-high.
REQ-005 SHALL have the following ports, in this order:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- s_wb_cyc  in  1  bus cycle
- s_wb_stb  in  1  strobe
- s_wb_we  in  1  write enable
- s_wb_addr  in  ADDRESS_WIDTH  byte address
- s_wb_data_i  in  DW  write data
- s_wb_sel  in  BUS_WIDTH  byte select
- s_wb_cti  in  3  cycle type
- s_wb_bte  in  2  burst type
- s_wb_ack  out  1  beat acknowledge
- s_wb_err  out  1  beat error
- s_wb_data_o  out  DW  read data
- up_rreq  out  1  read request
- up_rack  in  1  read acknowledge
- up_raddr  out  ADDRESS_WIDTH-WS  read word address
- up_rdata  in  DW  read data
- up_wreq  out  1  write request
- up_wack  in  1  write acknowledge
- up_waddr  out  ADDRESS_WIDTH-WS  write word address
- up_wdata  out  DW  write data
- up_wstrb  out  BUS_WIDTH  write byte strobe

Function
REQ-006 SHALL use an FSM with states IDLE, READ, WRITE and RESP.
- IDLE: on s_wb_cyc & s_wb_stb with s_wb_ack and s_wb_err both low, latch the beat and go to READ when s_wb_we=0, or WRITE when s_wb_we=1.
REQ-007 SHALL latch the beat's word address, data and select. up_*addr is the latched word address, up_wdata the latched data, up_wstrb the latched s_wb_sel; all are held stable while the request is pending.
REQ-008 SHALL drive up_rreq high for exactly the READ state and up_wreq high for exactly the WRITE state; both requests SHALL never be high together.
REQ-009 SHALL complete a read on the edge where up_rreq & up_rack: register up_rdata into s_wb_data_o, assert s_wb_ack for one cycle, and go to RESP.
REQ-010 SHALL complete a write on the edge where up_wreq & up_wack: assert s_wb_ack for one cycle and go to RESP; s_wb_data_o is unchanged.
REQ-011 SHALL give a latency of 2 cycles from stb sampled to ack when the uP acks on the first request cycle; each further cycle of uP wait adds 1 cycle.
REQ-012 SHALL leave RESP for IDLE after one cycle, so s_wb_ack/s_wb_err are never high for two consecutive cycles.
REQ-013 SHALL keep a wait counter that is cleared on entry to READ/WRITE and increments each cycle the request is pending.
- When the counter reaches TIMEOUT_CYCLES (nonzero) without an ack: drop the request, pulse s_wb_err for one cycle, set s_wb_data_o = 0, go to RESP.
REQ-014 SHALL give the ack priority when the uP ack and the timeout occur on the same edge: ack, no error.
REQ-015 SHALL compute the burst address as follows.
- A burst starts on a beat with s_wb_cti=3'b010, taking its address from s_wb_addr.
- Each later beat with a burst in progress ignores s_wb_addr and uses the previous word address + 1.
- Wrap is set by s_wb_bte:
  - 00: linear, full-width wrap at the address maximum.
  - 01, 10, 11: wrap within an aligned 4-, 8- or 16-word block; the upper bits are preserved.
REQ-016 SHALL end a burst after any beat with cti=3'b111 or 3'b000, after an error, or when s_wb_cyc is low in IDLE; the next beat then uses s_wb_addr.
REQ-017 SHALL handle s_wb_cyc dropping in READ/WRITE as follows: hold the request until the uP ack or timeout, suppress s_wb_ack/s_wb_err, end the burst, and return to IDLE.
REQ-018 SHALL treat stb without cyc as no request.

Reset
REQ-019 SHALL, while rst is high, force:
- FSM to IDLE; wait counter and burst state cleared.
- s_wb_ack=0, s_wb_err=0, s_wb_data_o=0.
- up_rreq=0, up_wreq=0, up_raddr=0, up_waddr=0, up_wdata=0, up_wstrb=0.
REQ-020 SHALL abandon a pending request when rst asserts mid-request, issuing no ack or err; the first transaction after reset release is accepted normally.

Verification
REQ-021 Classic read: addr=0x0008, cti=000, up_rack on the first request cycle, up_rdata=0xB0BDBEEF -> up_raddr=0x0002; s_wb_ack for one cycle, 2 cycles after stb; s_wb_data_o=0xB0BDBEEF.
REQ-022 Write with byte select: addr=0x000C, data=0xAAAA0005, sel=4'b0011, uP acks after 3 cycles -> up_waddr=0x0003, up_wdata=0xAAAA0005, up_wstrb=0011 held stable for 3 cycles; one ack pulse.
REQ-023 Wrap-4 burst read: start addr=0x0008, cti=010 on beats 1-3 and 111 on beat 4, bte=01 -> up_raddr sequence 2,3,0,1; 4 ack pulses; s_wb_addr changes during the burst are ignored.
REQ-024 Timeout: TIMEOUT_CYCLES=8, read with up_rack held low -> up_rreq drops after 8 cycles; s_wb_err for one cycle; s_wb_data_o=0; s_wb_ack stays 0. The same test with up_rack on cycle 8 -> ack, no err.
REQ-025 Abort and reset: s_wb_cyc drops during a pending write, uP acks 2 cycles later -> no s_wb_ack, FSM in IDLE. Then rst pulses during a pending read -> all outputs 0, and the following read completes normally.
